// File: rtl/clk_rst_pkg.sv
// Shared types for the clock/reset controller: FSM states, reset-cause codes
// and the counter-width helper.
package clk_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_t;

  typedef logic [1:0] rst_cause_t;

  localparam rst_cause_t RC_RST  = 2'b00;
  localparam rst_cause_t RC_LOCK = 2'b01;
  localparam rst_cause_t RC_BTN  = 2'b10;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_rst_if.sv
// Board-side signals of the clock/reset controller: PLL lock and reset button
// in, system reset, CPU clock-enable strobe and reset cause out.
interface clk_rst_if;
  import clk_rst_pkg::*;

  logic       pll_lock;
  logic       btn_reset_n;
  logic       sys_rst_n;
  logic       cpu_clken;
  rst_cause_t rst_cause;

  modport master (
    output pll_lock,
    output btn_reset_n,
    input  sys_rst_n,
    input  cpu_clken,
    input  rst_cause
  );

  modport slave (
    input  pll_lock,
    input  btn_reset_n,
    output sys_rst_n,
    output cpu_clken,
    output rst_cause
  );

endinterface

// File: rtl/clk_rst_ctrl_debounce.sv
// Two-flop synchronizer plus stable-level counter for a bouncing button;
// dout follows din only after DEBOUNCE_CYCLES consecutive differing samples.
module debounce
  import clk_rst_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_async,
  output logic dout
);

  localparam int unsigned    CW       = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q   <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      db_q   <= db_d;
      cnt_q  <= cnt_d;
    end
  end

  // Any sample that agrees with the accepted level restarts the count.
  always_comb begin
    sync_d = {sync_q[0], din_async};
    db_d   = db_q;
    cnt_d  = '0;
    if (sync_q[1] != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign dout = db_q;

endmodule

// File: rtl/clk_rst_ctrl.sv
// System reset sequencer: waits for PLL lock, holds reset for a fixed count,
// then runs with a divided CPU clock-enable; lock loss or a button press restarts.
module clk_rst_ctrl
  import clk_rst_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 64,
  parameter int unsigned CPU_CLKEN_DIV   = 25,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic      clk25,
  input  logic      rst_n,
  clk_rst_if.slave  bus
);

  localparam int unsigned   HW        = cnt_w(RST_HOLD_CYCLES);
  localparam int unsigned   DW        = cnt_w(CPU_CLKEN_DIV);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CPU_CLKEN_DIV - 1);

  state_t     state_q, state_d;
  logic [1:0] lock_sync_q, lock_sync_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic       sys_rst_n_q, sys_rst_n_d;
  logic       cpu_clken_q, cpu_clken_d;
  rst_cause_t rst_cause_q, rst_cause_d;
  logic       btn_db_prev_q, btn_db_prev_d;
  logic       btn_db;
  logic       lock_sync;
  logic       btn_fall;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk       (clk25),
    .rst_n     (rst_n),
    .din_async (bus.btn_reset_n),
    .dout      (btn_db)
  );

  assign lock_sync_d   = {lock_sync_q[0], bus.pll_lock};
  assign lock_sync     = lock_sync_q[1];
  assign btn_db_prev_d = btn_db;
  assign btn_fall      = btn_db_prev_q & ~btn_db;

  always_ff @(posedge clk25) begin
    if (!rst_n) begin
      state_q       <= WAIT_LOCK;
      lock_sync_q   <= '0;
      hold_cnt_q    <= '0;
      div_cnt_q     <= '0;
      sys_rst_n_q   <= 1'b0;
      cpu_clken_q   <= 1'b0;
      rst_cause_q   <= RC_RST;
      btn_db_prev_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      lock_sync_q   <= lock_sync_d;
      hold_cnt_q    <= hold_cnt_d;
      div_cnt_q     <= div_cnt_d;
      sys_rst_n_q   <= sys_rst_n_d;
      cpu_clken_q   <= cpu_clken_d;
      rst_cause_q   <= rst_cause_d;
      btn_db_prev_q <= btn_db_prev_d;
    end
  end

  // Lock loss is tested first so it wins over a press in the same cycle.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = '0;
    rst_cause_d = rst_cause_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_sync) state_d = HOLD;
      end
      HOLD: begin
        if (!lock_sync) begin
          state_d     = WAIT_LOCK;
          rst_cause_d = RC_LOCK;
        end else if (btn_db) begin
          if (hold_cnt_q == HOLD_LAST) state_d = RUN;
          else                         hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_sync) begin
          state_d     = WAIT_LOCK;
          rst_cause_d = RC_LOCK;
        end else if (btn_fall) begin
          state_d     = HOLD;
          rst_cause_d = RC_BTN;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Outputs are decoded from the next state so the flops track the state register.
  always_comb begin
    sys_rst_n_d = (state_d == RUN);
    div_cnt_d   = '0;
    if (state_d == RUN && state_q == RUN) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + 1'b1;
    end
    cpu_clken_d = (state_d == RUN) && (div_cnt_d == DIV_LAST);
  end

  assign bus.sys_rst_n = sys_rst_n_q;
  assign bus.cpu_clken = cpu_clken_q;
  assign bus.rst_cause = rst_cause_q;

endmodule

// File: doc/clk_rst_ctrl.md
CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

Interface
REQ-001 SHALL have parameter RST_HOLD_CYCLES, 64, clk25 cycles sys_rst_n is held low after lock/button release (>=2).
REQ-002 SHALL have parameter CPU_CLKEN_DIV, 25, clk25 cycles per cpu_clken strobe (>=2; 25 gives 1 MHz).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change (>=2).
REQ-004 SHALL have port clk25  input  1  the single clock, 25 MHz PLL global output.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port pll_lock  input  1  PLL LOCK; asynchronous to clk25.
REQ-007 SHALL have port btn_reset_n  input  1  raw user reset button, active-low, asynchronous, bouncing.
REQ-008 SHALL have port sys_rst_n  output  1  system reset to CPU/peripherals, active-low, driven from a flop.
REQ-009 SHALL have port cpu_clken  output  1  one-cycle CPU clock-enable strobe, driven from a flop.
REQ-010 SHALL have port rst_cause  output  2  cause of the most recent reset: 00 rst_n, 01 lock loss, 10 button.

Function
REQ-011 SHALL pass pll_lock and btn_reset_n each through a 2-flop synchronizer before any use.
REQ-012 SHALL debounce the synchronized button: btn_db changes only after the synchronized input differs from btn_db for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the counter.
REQ-013 SHALL implement states WAIT_LOCK, HOLD, RUN.
REQ-014 WAIT_LOCK: sys_rst_n=0; go to HOLD with hold counter=0 on the first cycle lock_sync=1.
REQ-015 HOLD: sys_rst_n=0; hold counter increments each cycle; go to RUN when counter = RST_HOLD_CYCLES-1.
REQ-016 HOLD: while btn_db=0 (pressed) the hold counter SHALL be held at 0.
REQ-017 RUN: sys_rst_n=1; btn_db falling (press) -> HOLD, counter=0, rst_cause=10.
REQ-018 Any state: lock_sync=0 -> WAIT_LOCK, rst_cause=01; lock loss has priority over button in the same cycle.
REQ-019 sys_rst_n SHALL be 1 exactly in the cycles the state register holds RUN (no combinational decode on output).
REQ-020 Divider counter SHALL be 0 outside RUN and count 0..CPU_CLKEN_DIV-1 with wrap in RUN.
REQ-021 cpu_clken SHALL pulse for exactly one cycle every CPU_CLKEN_DIV cycles, first pulse in the CPU_CLKEN_DIV-th cycle of RUN; never asserted while sys_rst_n=0.
REQ-022 Leaving RUN SHALL deassert cpu_clken in the same cycle sys_rst_n falls; no partial strobe afterwards.
REQ-023 Counter widths SHALL be $clog2 of their parameter (minimum 1 bit); no counter may wrap outside the stated ranges.

Reset
REQ-024 rst_n=0 sampled on a clk25 edge SHALL set state=WAIT_LOCK, sys_rst_n=0, cpu_clken=0, rst_cause=00, all counters 0, synchronizer flops 0, btn_db=1.
REQ-025 rst_n asserted mid-operation (any state) SHALL take effect on the next edge with the values of REQ-024, overriding all other transitions.
REQ-026 rst_n SHALL not be synchronized internally; it is already in the clk25 domain.

Structure
REQ-027 Shared package clk_rst_pkg SHALL hold the state enum and the rst_cause encodings (RC_RST, RC_LOCK, RC_BTN).
REQ-028 One sub-module, debounce (synchronizer + stable counter, parameter DEBOUNCE_CYCLES), SHALL be instantiated for btn_reset_n.
REQ-029 Lock synchronizer, state machine, hold and divider counters SHALL live in clk_rst_ctrl.

Verification (RST_HOLD_CYCLES=64, CPU_CLKEN_DIV=25, DEBOUNCE_CYCLES=16)
REQ-030 rst_n released, pll_lock rises at edge 0 -> sys_rst_n rises after edge 67 (2 sync + 1 + 64), rst_cause=00.
REQ-031 In RUN -> first cpu_clken in 25th RUN cycle, then every 25 cycles, width 1; 1000 cycles give 40 pulses.
REQ-032 btn_reset_n bounces 0/1 every 5 cycles for 100 cycles then stays 1 -> sys_rst_n stays 1; held 0 for 20 cycles -> sys_rst_n falls 2+16+1 edges after press, rst_cause=10, rises 64 cycles after debounced release.
REQ-033 pll_lock drops for 3 cycles in RUN -> sys_rst_n and cpu_clken 0 two edges later, rst_cause=01, full 64-cycle HOLD after relock.
REQ-034 lock loss and debounced press in same cycle -> WAIT_LOCK, rst_cause=01.
REQ-035 rst_n pulsed low 1 cycle during HOLD count 30 -> all outputs per REQ-024 next edge; restart from WAIT_LOCK.
